key_debounce: RTL
=================

Name: key_debounce

Overview:
- Input-side counterpart to the board LED drivers: a mechanical pushbutton is sampled, synchronised, debounced, and turned into a clean level plus single-cycle press/release events.
- Sits between a raw board pin and user logic such as an LED toggle or mode select.
- Targets the 12 MHz board clock; the default timing constants are sized for that clock.

Parameters:
- CNT_DEB, 240_000 - 1, debounce window minus 1 in clk cycles (20 ms at 12 MHz); must fit in 24 bits.
- CNT_LONG, 12_000_000 - 1, long-press threshold minus 1 in clk cycles (1 s at 12 MHz); must fit in 24 bits.
- KEY_ACTIVE, 1'b0, pin level meaning "pressed" (board keys pull low).

Ports:
- clk  input  1  system clock, 12 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- key_in  input  1  raw asynchronous button pin.
- key_state  output  1  debounced level; 1 = pressed.
- key_press  output  1  one-cycle pulse on a debounced press.
- key_release  output  1  one-cycle pulse on a debounced release.
- key_long  output  1  one-cycle pulse when the hold reaches the long-press threshold.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All flops are reset by rst_n only.
- Reset values:
  - key_state, key_press, key_release, key_long = 0.
  - FSM = IDLE; counters = 0.
  - Sync flops = ~KEY_ACTIVE, so a held key at reset release is not seen as a spurious edge.
- Synchroniser: two flops, s1 <= key_in, s2 <= s1. pressed = (s2 == KEY_ACTIVE).
- Debounce counter: 24 bits; cleared on every FSM state change.
- FSM (2-bit, registered):
  - IDLE: if pressed, go to PRESS_FILT with cnt = 0.
  - PRESS_FILT:
    - If !pressed, go to IDLE with no output (bounce rejected).
    - Else if cnt == CNT_DEB, go to DOWN; key_state <= 1; key_press pulses.
    - Else cnt++.
  - DOWN: if !pressed, go to REL_FILT with cnt = 0.
  - REL_FILT:
    - If pressed, return to DOWN with no output and no second key_press.
    - Else if cnt == CNT_DEB, go to IDLE; key_state <= 0; key_release pulses.
    - Else cnt++.
- Latency:
  - key_press is high in the cycle following rising edge number CNT_DEB+4, counting the first edge that samples key_in active as edge 1.
  - key_release has the same latency from the first inactive sample.
- Stability requirement: pressed must hold for CNT_DEB+1 consecutive FSM cycles. Any glitch inside the window restarts filtering from IDLE (press side) or DOWN (release side).
- Pulse outputs are registered, exactly 1 cycle wide, and never assert together in one cycle.
- key_state changes in the same cycle its pulse asserts.
- Reset mid-operation: everything returns to reset values immediately. An in-flight press produces no pulse. After reset, a still-held key requires a full debounce before key_press.

Optional Feature:
- Macro KEY_LONG_PRESS_EN.
- Defined:
  - A 24-bit hold counter clears on PRESS_FILT->DOWN and increments in DOWN and REL_FILT.
  - When it equals CNT_LONG, key_long pulses for 1 cycle and the counter saturates. At most one key_long per press.
  - A short release bounce (REL_FILT->DOWN) does not clear the hold counter.
- Not defined: no hold counter is built; key_long is tied to 0. The port list is identical in both builds.

Test Plan (sim parameters CNT_DEB=9, CNT_LONG=49, KEY_ACTIVE=0):
- Reset values: assert rst_n=0 with key_in=0 (pressed) -> all outputs 0. Release reset while holding key_in=0 -> key_press after exactly 13 edges, key_state=1.
- Clean press: key_in 1->0 held 30 cycles, then 0->1 -> key_press once, 13 cycles after the falling sample. key_release once, 13 cycles after the rising sample. key_state high between them.
- Press bounce: key_in low 5 cycles, high 2, low 20 -> no pulse during the glitch. key_press 13 cycles after the final low. Exactly one pulse.
- Release bounce: while pressed, key_in high 4 cycles then low again -> no key_release, no extra key_press, key_state stays 1.
- Reset mid-filter: assert rst_n at PRESS_FILT cnt=5 -> outputs 0 immediately, no key_press. After release, full 13-cycle debounce is required.
- KEY_LONG_PRESS_EN: hold 120 cycles -> key_long pulses once, 50 cycles after key_press. Without the macro, key_long stays 0. Hold 40 cycles (with the macro) -> no key_long.

Source files
------------

// File: rtl/key_debounce.sv
// key_debounce: pushbutton synchroniser, debouncer and press/release/long-press
// event generator.
//
// Optional build macro: KEY_LONG_PRESS_EN
//   defined   - a hold counter drives a one-shot key_long pulse after CNT_LONG
//   undefined - no hold counter is built and key_long is tied low
//
// state      | meaning
// -----------+-----------------------------------------------------
// IDLE       | key released and stable
// PRESS_FILT | key seen pressed, waiting for it to stay stable
// DOWN       | debounced pressed level
// REL_FILT   | key seen released, waiting for it to stay stable

module key_debounce #(
    parameter logic [23:0] CNT_DEB    = 24'd239_999,
    parameter logic [23:0] CNT_LONG   = 24'd11_999_999,
    parameter logic        KEY_ACTIVE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        s1, s2;
    logic        pressed;
    logic [23:0] cnt, cnt_nxt;
    logic        key_state_nxt;
    logic        press_nxt;
    logic        release_nxt;

    // Two-flop synchroniser; resets to the idle pin level so a key held
    // through reset is not mistaken for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= ~KEY_ACTIVE;
            s2 <= ~KEY_ACTIVE;
        end else begin
            s1 <= key_in;
            s2 <= s1;
        end
    end

    assign pressed = (s2 == KEY_ACTIVE);

    // State, window counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            key_state   <= key_state_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
        end
    end

    // Next-state logic; the window counter restarts on every state change.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        key_state_nxt = key_state;
        press_nxt     = 1'b0;
        release_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (pressed) begin
                    state_nxt = PRESS_FILT;
                    cnt_nxt   = '0;
                end
            end
            PRESS_FILT: begin
                if (!pressed) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_DEB) begin
                    state_nxt     = DOWN;
                    cnt_nxt       = '0;
                    key_state_nxt = 1'b1;
                    press_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt + 24'd1;
                end
            end
            DOWN: begin
                if (!pressed) begin
                    state_nxt = REL_FILT;
                    cnt_nxt   = '0;
                end
            end
            REL_FILT: begin
                if (pressed) begin
                    state_nxt = DOWN;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_DEB) begin
                    state_nxt     = IDLE;
                    cnt_nxt       = '0;
                    key_state_nxt = 1'b0;
                    release_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 24'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

`ifdef KEY_LONG_PRESS_EN
    logic [23:0] hold_cnt;
    logic        long_done;

    // Hold counter runs while the key is debounced-down (release bounces
    // included), saturates at the threshold and fires key_long once per press.
    // A release landing on the same cycle wins so pulses never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
            key_long  <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if (press_nxt) begin
                hold_cnt  <= '0;
                long_done <= 1'b0;
            end else if (state == DOWN || state == REL_FILT) begin
                if (hold_cnt == CNT_LONG) begin
                    long_done <= 1'b1;
                    key_long  <= !long_done && !release_nxt;
                end else begin
                    hold_cnt <= hold_cnt + 24'd1;
                end
            end
        end
    end
`else
    // Threshold only matters when the hold counter is built.
    logic long_unused;
    assign long_unused = ^CNT_LONG;
    assign key_long    = 1'b0;
`endif

endmodule
